// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative encryption core.
package aes_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StDone
  } aes_fsm_e;

  localparam aes_byte_t GfPoly = 8'h1B;

  function automatic aes_byte_t xtime(aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GfPoly : 8'h00);
  endfunction

  // col[31:24] is row 0 of the column.
  function automatic aes_word_t mix_column(aes_word_t col);
    aes_byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Source byte index feeding output byte k after ShiftRows.
  function automatic int unsigned shift_src(int unsigned k);
    int unsigned r, c;
    r = k % 4;
    c = k / 4;
    return 4 * ((c + r) % 4) + r;
  endfunction

endpackage

// File: rtl/aes_enc_iter_core_if.sv
// Block-in / ciphertext-out handshake bundle of the iterative AES encryption core.
interface aes_enc_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (single byte).
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SboxTab[2047 - 8 * data_i -: 8];

endmodule

// File: rtl/aes_enc_iter_core.sv
// Iterative AES encryption datapath, one round per clock.
// Optional AES_ENC_ZEROIZE_EN: clear state after handoff and mask data_out when not valid.
module aes_enc_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_enc_iter_core_if.slave  bus,
  output logic [3:0]          rk_idx_o,
  input  logic [127:0]        rk_i
);

  localparam logic [3:0] LastRnd = 4'(NR);

  aes_fsm_e   fsm_q, fsm_d;
  logic [3:0] rnd_q, rnd_d;
  aes_state_t state_q, state_d;
  aes_state_t sub_bytes, shift_rows, mix_cols;

  logic       in_ready, out_valid;
  logic [3:0] rk_idx;

  for (genvar k = 0; k < 16; k++) begin : g_bytes
    localparam int unsigned Src = shift_src(k);
    aes_sbox u_sbox (
      .data_i(state_q[127 - 8 * k -: 8]),
      .data_o(sub_bytes[127 - 8 * k -: 8])
    );
    assign shift_rows[127 - 8 * k -: 8] = sub_bytes[127 - 8 * Src -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_cols
    assign mix_cols[127 - 32 * c -: 32] = mix_column(shift_rows[127 - 32 * c -: 32]);
  end

  always_comb begin
    fsm_d     = fsm_q;
    rnd_d     = rnd_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd0;
    unique case (fsm_q)
      StIdle: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = bus.data_in ^ rk_i;
          rnd_d   = 4'd1;
          fsm_d   = StRound;
        end
      end
      StRound: begin
        rk_idx = rnd_q;
        if (rnd_q == LastRnd) begin
          state_d = shift_rows ^ rk_i;
          fsm_d   = StDone;
        end else begin
          state_d = mix_cols ^ rk_i;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          fsm_d = StIdle;
          rnd_d = 4'd0;
`ifdef AES_ENC_ZEROIZE_EN
          state_d = '0;
`endif
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      rnd_q   <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign rk_idx_o      = rk_idx;

`ifdef AES_ENC_ZEROIZE_EN
  assign bus.data_out = out_valid ? state_q : '0;
`else
  assign bus.data_out = state_q;
`endif

endmodule

// File: tb/tb_aes_enc_iter_core.sv
// Self-checking bench for aes_enc_iter_core: AES reference model built from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_aes_enc_iter_core;

  localparam int NR = 10;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RkB10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PtC   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_ENC_ZEROIZE_EN
  localparam bit Zeroize = 1'b1;
`else
  localparam bit Zeroize = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] rkt [16];
  logic [7:0]   sbt [256];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit rec_en   = 1'b0;
  logic prev_ov = 1'b0;
  int acc_q[$];
  int ov_q[$];
  logic [127:0] ov_dq[$];
  int idx_q[$];

  aes_enc_iter_core_if bus ();

  aes_enc_iter_core #(.NR(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rk_idx_o (rk_idx),
    .rk_i     (rk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rk = rkt[rk_idx];

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbt[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rkt[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int k);
    return s[127 - 8 * k -: 8];
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = sbt[gb(s, k)];
    return o;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = gb(s, 4 * ((c + r) % 4) + r);
    return o;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = gmul(8'h02, gb(s, 4 * c + r))
                                      ^ gmul(8'h03, gb(s, 4 * c + (r + 1) % 4))
                                      ^ gb(s, 4 * c + (r + 2) % 4)
                                      ^ gb(s, 4 * c + (r + 3) % 4);
    return o;
  endfunction

  // AES state after n rounds applied to plaintext pt with the current key table.
  function automatic logic [127:0] state_after(input logic [127:0] pt, input int n);
    logic [127:0] s;
    s = pt ^ rkt[0];
    for (int j = 1; j <= n; j++) begin
      s = shift_r(sub_b(s));
      if (j < NR) s = mix_c(s);
      s = s ^ rkt[j];
    end
    return s;
  endfunction

  // ---------------- transaction model ----------------
  int           m_ph;   // 0 waiting for block, 1 computing, 2 holding result
  int           m_rnd;  // rounds completed on current block
  logic [127:0] m_pt, m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= 0;
      m_rnd  <= 0;
      m_last <= '0;
    end else begin
      case (m_ph)
        0: if (bus.in_valid) begin
          m_ph  <= 1;
          m_rnd <= 0;
          m_pt  <= bus.data_in;
        end
        1: begin
          m_rnd <= m_rnd + 1;
          if (m_rnd + 1 == NR) m_ph <= 2;
        end
        default: if (bus.out_ready) begin
          m_ph   <= 0;
          m_last <= Zeroize ? '0 : state_after(m_pt, NR);
        end
      endcase
    end
  end

  function automatic logic [127:0] exp_dout();
    if (m_ph == 0) return Zeroize ? '0 : m_last;
    if (m_ph == 1) return Zeroize ? '0 : state_after(m_pt, m_rnd);
    return state_after(m_pt, NR);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", 128'(bus.in_ready), 128'(m_ph == 0));
      check("out_valid", 128'(bus.out_valid), 128'(m_ph == 2));
      check("rk_idx", 128'(rk_idx), (m_ph == 1) ? 128'(m_rnd + 1) : 128'(0));
      check("data_out", bus.data_out, exp_dout());
      n_checks++;
      assert (int'(rk_idx) <= NR) else begin
        n_fails++;
        $display("FAIL rk_idx_range: got %0d required <= %0d", rk_idx, NR);
      end
    end
    if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
    if (bus.out_valid && !prev_ov) begin
      ov_q.push_back(cyc);
      ov_dq.push_back(bus.data_out);
    end
    if (rec_en) idx_q.push_back(int'(rk_idx));
  end

  always @(negedge clk) prev_ov <= bus.out_valid;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [127:0] pt);
    int n0;
    n0 = acc_q.size();
    bus.data_in  = pt;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && acc_q.size() == n0; i++) tick();
    if (acc_q.size() == n0) begin
      n_checks++; n_fails++;
      $display("FAIL accept_timeout: got no accept required accept within 40 cycles");
      acc_q.push_back(0);
    end
  endtask

  task automatic wait_out();
    int o0;
    o0 = ov_q.size();
    for (int i = 0; i < 40 && ov_q.size() == o0; i++) tick();
    if (ov_q.size() == o0) begin
      n_checks++; n_fails++;
      $display("FAIL out_valid_timeout: got no out_valid required within 40 cycles");
      ov_q.push_back(0);
      ov_dq.push_back('0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, n0, o0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;

    // Pin the reference model against FIPS-197 literals.
    build_sbox();
    check("sbox_00", 128'(sbt[8'h00]), 128'h63);
    check("sbox_53", 128'(sbt[8'h53]), 128'hed);
    set_key(KeyC);
    check("model_ctC", state_after(PtC, NR), CtC);
    set_key(KeyB);
    check("model_rk10", rkt[10], RkB10);
    check("model_ctB", state_after(PtB, NR), CtB);

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_rk_idx", 128'(rk_idx), 128'(0));
    check("rst_data_out", bus.data_out, '0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // App. B vector, latency.
    bus.out_ready = 1'b1;
    send(PtB);
    bus.in_valid = 1'b0;
    wait_out();
    check("appB_ct", ov_dq[$], CtB);
    check("appB_latency", 128'(ov_q[$] - acc_q[$]), 128'(NR));
    tick();
    check("idle_data_out", bus.data_out, Zeroize ? 128'h0 : CtB);

    // App. C.1 vector and rk_idx walk.
    set_key(KeyC);
    idx_q.delete();
    rec_en = 1'b1;
    send(PtC);
    bus.in_valid = 1'b0;
    wait_out();
    rec_en = 1'b0;
    check("c1_ct", ov_dq[$], CtC);
    check("c1_idx_len", 128'(idx_q.size()), 128'(NR + 2));
    for (int i = 0; i < idx_q.size() && i < NR + 2; i++)
      check("c1_idx_seq", 128'(idx_q[i]), 128'((i == NR + 1) ? 0 : i));

    // Backpressure: result held, second block waits for the handshake.
    set_key(KeyB);
    bus.out_ready = 1'b0;
    send(PtB);
    bus.in_valid = 1'b0;
    wait_out();
    bus.data_in  = PtC;
    bus.in_valid = 1'b1;
    n0 = acc_q.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data_out", bus.data_out, CtB);
      check("bp_in_ready", 128'(bus.in_ready), 128'(0));
    end
    check("bp_no_accept", 128'(acc_q.size()), 128'(n0));
    bus.out_ready = 1'b1;
    hs = cyc + 1;
    send(PtC);
    bus.in_valid = 1'b0;
    check("bp_accept_after_hs", 128'(acc_q[$] - hs), 128'(1));
    wait_out();
    check("bp_second_ct", ov_dq[$], state_after(PtC, NR));

    // Asynchronous reset in round 5, then a clean block.
    send(PtB);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_rk_idx", 128'(rk_idx), 128'(5));
    o0 = ov_q.size();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("mid_rst_data_out", bus.data_out, '0);
    check("mid_rst_rk_idx", 128'(rk_idx), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_no_output", 128'(ov_q.size()), 128'(o0));
    send(PtB);
    bus.in_valid = 1'b0;
    wait_out();
    check("post_rst_ct", ov_dq[$], CtB);
    check("post_rst_latency", 128'(ov_q[$] - acc_q[$]), 128'(NR));
    tick();

    // Back-to-back with in_valid and out_ready held high.
    n0 = acc_q.size();
    o0 = ov_q.size();
    bus.data_in  = PtB;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60 && acc_q.size() < n0 + 2; i++) tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40 && ov_q.size() < o0 + 2; i++) tick();
    check("b2b_accepts", 128'(acc_q.size() - n0), 128'(2));
    check("b2b_outputs", 128'(ov_q.size() - o0), 128'(2));
    if (acc_q.size() >= n0 + 2 && ov_q.size() >= o0 + 2) begin
      check("b2b_accept_spacing", 128'(acc_q[n0+1] - acc_q[n0]), 128'(NR + 2));
      check("b2b_out_spacing", 128'(ov_q[o0+1] - ov_q[o0]), 128'(NR + 2));
      check("b2b_ct0", ov_dq[o0], CtB);
      check("b2b_ct1", ov_dq[o0+1], CtB);
    end
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
